mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have an input `CLK`, 1 bit: the clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have an input `nRST`, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have an input `start`, 1 bit: an operation request, valid for one cycle.
REQ-004 The block SHALL have an input `op`, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
REQ-005 The block SHALL have an input `rs_val`, 32 bits: first operand (multiplicand/dividend; MTHI/MTLO source).
REQ-006 The block SHALL have an input `rt_val`, 32 bits: second operand (multiplier/divisor).
REQ-007 The block SHALL have an input `rd`, 5 bits: destination register index for MFHI/MFLO.
REQ-008 The block SHALL have an output `busy`, 1 bit: a multiply/divide iteration is in progress.
REQ-009 The block SHALL have an output `stall`, 1 bit: the current `start` is refused; upstream holds the instruction.
REQ-010 The block SHALL have an output `wen`, 1 bit: register-file write enable.
REQ-011 The block SHALL have an output `wsel`, 5 bits: register-file write index.
REQ-012 The block SHALL have an output `wdat`, 32 bits: register-file write data.
REQ-013 The block SHALL have outputs `hi` and `lo`, 32 bits each: architectural HI/LO, exposed for debug.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and BUSY; `busy` SHALL be 1 exactly in BUSY.
REQ-015 `stall` SHALL be combinational: `stall` = `start` AND `busy`; a refused request SHALL cause no state change.
REQ-016 A request SHALL be accepted on a rising edge where `start`=1 and `busy`=0.
REQ-017 MULT/MULTU/DIV/DIVU accepted: IDLE -> BUSY; operands latched; 6-bit iteration counter loaded with 32.
REQ-018 In BUSY, one iteration SHALL execute per cycle: a shift-add step for multiply, a restoring subtract-shift step for divide.
REQ-019 `busy` SHALL remain high for exactly 32 cycles after acceptance; on the 32nd BUSY edge, HI/LO SHALL update and the state SHALL return to IDLE.
REQ-020 Multiply SHALL produce a 64-bit product with {HI,LO} = product; MULT is signed, MULTU unsigned.
REQ-021 Divide SHALL produce LO = quotient and HI = remainder; DIV is signed, DIVU unsigned.
REQ-022 Signed operations SHALL iterate on operand magnitudes and sign-correct at completion.
REQ-023 Signed quotient SHALL truncate toward zero, and the signed remainder SHALL take the sign of the dividend.
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wrap, no trap).
REQ-025 Divide by zero SHALL still take 32 cycles and SHALL give LO=0xFFFFFFFF, HI=dividend (raw `rs_val`), for both DIV and DIVU.
REQ-026 MTHI/MTLO accepted: HI (resp. LO) SHALL be loaded with `rs_val` on the accepting edge; the state SHALL stay IDLE.
REQ-027 MFHI/MFLO accepted: on the cycle after acceptance, `wen`=1, `wsel`=`rd`, `wdat`=HI (resp. LO) as of the accepting edge; `wen` SHALL be high for one cycle only.
REQ-028 MFHI/MFLO with `rd`=0 SHALL keep `wen`=0.
REQ-029 `wen` SHALL be 0 in every cycle except the single cycle defined in REQ-027.
REQ-030 A `start` arriving in the same cycle as the final BUSY edge SHALL be stalled, since `busy` is still 1; it SHALL be accepted on the next cycle.
REQ-031 Back-to-back MTLO then MFLO in consecutive cycles SHALL return the newly written LO value.

Reset
REQ-032 While `nRST`=0, regardless of `CLK`: state=IDLE, counter=0, HI=0, LO=0, `busy`=0, `wen`=0, `wsel`=0, `wdat`=0.
REQ-033 Reset asserted mid-operation SHALL abandon the iteration and leave HI/LO=0.
REQ-034 After `nRST` deasserts, the first `start` SHALL be accepted normally.

Verification
REQ-035 The bench SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 32 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 The bench SHALL cover: MULT 0xFFFFFFFE x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-037 The bench SHALL cover: DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 The bench SHALL cover: DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5.
REQ-039 The bench SHALL cover: MFLO with `rd`=9 issued during BUSY -> `stall`=1 every cycle until `busy` falls; one cycle after acceptance, `wen`=1, `wsel`=9, `wdat`=new LO.
REQ-040 The bench SHALL cover: MULT started, `nRST` pulsed at busy cycle 10 -> `busy`=0, HI=LO=0 immediately; MTHI 0x1234 then MFHI `rd`=0 -> HI=0x1234, `wen` stays 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers and MFHI/MFLO write-back.
// One shift-add or restoring-divide step per cycle; sign correction is applied on the final edge.
module mult_div_unit (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [4:0]  rd,
   output logic        busy,
   output logic        stall,
   output logic        wen,
   output logic [4:0]  wsel,
   output logic [31:0] wdat,
   output logic [31:0] hi,
   output logic [31:0] lo
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [2:0] OP_MFHI = 3'b100;
   localparam logic [2:0] OP_MFLO = 3'b101;
   localparam logic [2:0] OP_MTHI = 3'b110;
   localparam logic [2:0] OP_MTLO = 3'b111;

   state_t      state, next_state;
   logic [5:0]  cnt;
   logic [63:0] acc, acc_next;
   logic [31:0] a_raw, b_raw, b_mag, a_mag, diff, quo, rem;
   logic [63:0] prod;
   logic [32:0] madd;
   logic        is_div, is_signed, accept, ge, neg_q, neg_r, div_zero;

   assign busy   = (state == BUSY);
   assign stall  = start & busy;
   assign accept = start & ~busy;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (accept && !op[2]) next_state = BUSY;
         BUSY: if (cnt == 6'd1)      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
   always_comb begin
      a_mag = (!op[0] && rs_val[31]) ? -rs_val : rs_val;
      b_mag = (is_signed && b_raw[31]) ? -b_raw : b_raw;
      madd  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
      ge    = (acc[63:31] >= {1'b0, b_mag});
      diff  = acc[62:31] - b_mag;
      if (is_div) acc_next = ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      else        acc_next = {madd, acc[31:1]};
      neg_q    = is_signed & (a_raw[31] ^ b_raw[31]);
      neg_r    = is_signed & a_raw[31];
      div_zero = (b_raw == 32'd0);
      prod     = neg_q ? -acc_next : acc_next;
      quo      = neg_q ? -acc_next[31:0] : acc_next[31:0];
      rem      = neg_r ? -acc_next[63:32] : acc_next[63:32];
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt       <= 6'd0;
         acc       <= 64'd0;
         a_raw     <= 32'd0;
         b_raw     <= 32'd0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         wen       <= 1'b0;
         wsel      <= 5'd0;
         wdat      <= 32'd0;
      end else begin
         wen <= 1'b0;
         if (busy) begin
            cnt <= cnt - 6'd1;
            acc <= acc_next;
            if (cnt == 6'd1) begin
               if (!is_div) begin
                  hi <= prod[63:32];
                  lo <= prod[31:0];
               end else if (div_zero) begin
                  hi <= a_raw;
                  lo <= 32'hFFFF_FFFF;
               end else begin
                  hi <= rem;
                  lo <= quo;
               end
            end
         end else if (accept) begin
            case (op)
               OP_MFHI: begin
                  wen  <= (rd != 5'd0);
                  wsel <= rd;
                  wdat <= hi;
               end
               OP_MFLO: begin
                  wen  <= (rd != 5'd0);
                  wsel <= rd;
                  wdat <= lo;
               end
               OP_MTHI: hi <= rs_val;
               OP_MTLO: lo <= rs_val;
               default: begin
                  a_raw     <= rs_val;
                  b_raw     <= rt_val;
                  is_div    <= op[1];
                  is_signed <= ~op[0];
                  acc       <= {32'd0, a_mag};
                  cnt       <= 6'd32;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed expected HI/LO and write-back values.
module tb_mult_div_unit;
   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs_val = 32'd0;
   logic [31:0] rt_val = 32'd0;
   logic [4:0]  rd = 5'd0;
   logic        busy, stall, wen;
   logic [4:0]  wsel;
   logic [31:0] wdat, hi, lo;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
   localparam logic [2:0] MFHI = 3'd4, MFLO = 3'd5, MTHI = 3'd6, MTLO = 3'd7;

   mult_div_unit dut (
      .CLK(CLK), .nRST(nRST), .start(start), .op(op), .rs_val(rs_val),
      .rt_val(rt_val), .rd(rd), .busy(busy), .stall(stall), .wen(wen),
      .wsel(wsel), .wdat(wdat), .hi(hi), .lo(lo)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   // drive one request on the next rising edge, then drop start
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
      @(negedge CLK);
      start = 1'b1; op = o; rs_val = a; rt_val = b; rd = r;
      @(posedge CLK);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      @(negedge CLK);
      while (busy && n < 100) begin
         n++;
         @(negedge CLK);
      end
      chk(tag, n, 32);
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp_hilo);
      issue(o, a, b, 5'd0);
      wait_done({tag, "_cycles"});
      chk({tag, "_hilo"}, {hi, lo}, exp_hilo);
   endtask

   initial begin
      int n;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_hilo", {hi, lo}, 0);
      chk("rst_wb", {wen, wsel, wdat}, 0);
      @(negedge CLK);
      nRST = 1'b1;

      run("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run("mult_neg",  MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA);
      run("div_m7_2",  DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
      run("div_wrap",  DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run("div_7_m2",  DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      run("divu_z",    DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF);
      run("div_z",     DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF);
      run("divu_big",  DIVU,  32'hFFFF_FFFF, 32'd16,        64'h0000_000F_0FFF_FFFF);

      // MFLO held against a running MULTU must stall until busy falls
      issue(MULTU, 32'd6, 32'd7, 5'd0);
      start = 1'b1; op = MFLO; rd = 5'd9;
      n = 0;
      @(negedge CLK);
      while (busy && n < 100) begin
         n++;
         if (!stall || wen) chk("stall_hold", {stall, wen}, 2'b10);
         @(negedge CLK);
      end
      chk("stall_cycles", n, 32);
      chk("stall_clear", stall, 0);
      @(posedge CLK);
      #1 start = 1'b0;
      @(negedge CLK);
      chk("mflo_wb", {wen, wsel, wdat}, {1'b1, 5'd9, 32'd42});
      @(negedge CLK);
      chk("mflo_one_shot", wen, 0);

      // back-to-back MTLO then MFLO sees the new LO
      issue(MTLO, 32'hCAFE_F00D, 32'd0, 5'd0);
      chk("mtlo_idle", busy, 0);
      issue(MFLO, 32'd0, 32'd0, 5'd3);
      @(negedge CLK);
      chk("mtlo_mflo", {wen, wsel, wdat}, {1'b1, 5'd3, 32'hCAFE_F00D});

      // reset in the middle of a MULT
      issue(MTHI, 32'h55, 32'd0, 5'd0);
      issue(MULT, 32'd5, 32'd7, 5'd0);
      repeat (10) @(negedge CLK);
      chk("pre_rst_busy", busy, 1);
      nRST = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hilo", {hi, lo}, 0);
      @(negedge CLK);
      nRST = 1'b1;
      issue(MTHI, 32'h1234, 32'd0, 5'd0);
      chk("mthi_hi", hi, 32'h1234);
      issue(MFHI, 32'd0, 32'd0, 5'd0);
      @(negedge CLK);
      chk("mfhi_r0_wen", wen, 0);
      @(negedge CLK);
      chk("mfhi_r0_wen2", wen, 0);
      issue(MFHI, 32'd0, 32'd0, 5'd31);
      @(negedge CLK);
      chk("mfhi_wb", {wen, wsel, wdat}, {1'b1, 5'd31, 32'h1234});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
